// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Packet-level round-robin arbiter that shares the single UART transmit
// stream between NUM_REQ AXI-stream requesters. A grant is held from the
// first beat of a packet until the beat carrying tlast is accepted, so bytes
// from different requesters never interleave on the serial line. If the
// owner leaves s_tvalid low for TIMEOUT consecutive cycles mid-packet, the
// grant is forcibly released and timeout_pulse fires for one cycle.
//
// Ports:
//   clk            system clock
//   reset_n        asynchronous active-low reset
//   s_tdata        requester data, requester i at [i*WORD_LENGTH +: WORD_LENGTH]
//   s_tvalid       per-requester valid
//   s_tlast        per-requester end-of-packet
//   s_tready       per-requester ready (only the owner ever sees m_tready)
//   m_tdata        beat towards uart tx_data (zero while nobody owns the bus)
//   m_tvalid       towards uart tx_data_valid
//   m_tlast        towards uart tx_data_last
//   m_tready       from uart tx_data_ready
//   grant          one-hot current owner, all-zero when idle
//   timeout_pulse  one-cycle pulse when the watchdog releases an owner
// ----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int WORD_LENGTH = 8,
    parameter int TIMEOUT     = 1024,
    parameter int CW          = $clog2(TIMEOUT + 1)
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_REQ*WORD_LENGTH-1:0] s_tdata,
    input  logic [NUM_REQ-1:0]             s_tvalid,
    input  logic [NUM_REQ-1:0]             s_tlast,
    output logic [NUM_REQ-1:0]             s_tready,
    output logic [WORD_LENGTH-1:0]         m_tdata,
    output logic                           m_tvalid,
    output logic                           m_tlast,
    input  logic                           m_tready,
    output logic [NUM_REQ-1:0]             grant,
    output logic                           timeout_pulse
);

    localparam int PW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // With the watchdog disabled CW collapses to zero; keep a 1-bit counter.
    localparam int WDW   = (CW > 0) ? CW : 1;
    localparam bit WD_EN = (TIMEOUT > 0);
    localparam logic [WDW-1:0] WD_LAST = WD_EN ? WDW'(TIMEOUT - 1) : {WDW{1'b0}};
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    state_e               state_q;
    logic [NUM_REQ-1:0]   grant_q;
    logic [PW-1:0]        owner_q;
    logic [PW-1:0]        rr_ptr_q;
    logic [WDW-1:0]       wd_cnt_q;
    logic                 timeout_pulse_q;

    logic                 arb_hit_s;
    logic [PW-1:0]        arb_idx_s;
    logic                 hs_s;
    logic                 wd_fire_s;

    // Index 'offset' positions after 'base', wrapping modulo NUM_REQ (NUM_REQ
    // need not be a power of two, so plain bit truncation is not enough).
    function automatic logic [PW-1:0] rr_index(input logic [PW-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        return (sum >= NUM_REQ) ? PW'(sum - NUM_REQ) : PW'(sum);
    endfunction

    // AND-OR output mux driven only by the registered grant and owner inputs.
    always_comb begin
        m_tdata  = {WORD_LENGTH{1'b0}};
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            m_tdata  = m_tdata | (s_tdata[i*WORD_LENGTH +: WORD_LENGTH] & {WORD_LENGTH{grant_q[i]}});
            m_tvalid = m_tvalid | (s_tvalid[i] & grant_q[i]);
            m_tlast  = m_tlast | (s_tlast[i] & grant_q[i]);
        end
        s_tready = grant_q & {NUM_REQ{m_tready}};
    end

    // Round-robin search: first valid requester at or after rr_ptr_q wins.
    always_comb begin
        arb_hit_s = 1'b0;
        arb_idx_s = {PW{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!arb_hit_s && s_tvalid[rr_index(rr_ptr_q, k)]) begin
                arb_hit_s = 1'b1;
                arb_idx_s = rr_index(rr_ptr_q, k);
            end else begin
                arb_hit_s = arb_hit_s;
            end
        end
    end

    assign hs_s      = m_tvalid & m_tready;
    // Release fires on the TIMEOUT-th consecutive cycle without owner valid.
    assign wd_fire_s = WD_EN & ~m_tvalid & (wd_cnt_q == WD_LAST);

    assign grant         = grant_q;
    assign timeout_pulse = timeout_pulse_q;

    // Arbitration FSM: grant, round-robin pointer and idle watchdog.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            grant_q         <= {NUM_REQ{1'b0}};
            owner_q         <= {PW{1'b0}};
            rr_ptr_q        <= {PW{1'b0}};
            wd_cnt_q        <= {WDW{1'b0}};
            timeout_pulse_q <= 1'b0;
        end else begin
            timeout_pulse_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    wd_cnt_q <= {WDW{1'b0}};
                    if (arb_hit_s) begin
                        grant_q <= ONE_HOT0 << arb_idx_s;
                        owner_q <= arb_idx_s;
                        state_q <= ST_BUSY;
                    end else begin
                        grant_q <= {NUM_REQ{1'b0}};
                        state_q <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (hs_s && m_tlast) begin
                        grant_q  <= {NUM_REQ{1'b0}};
                        rr_ptr_q <= rr_index(owner_q, 1);
                        wd_cnt_q <= {WDW{1'b0}};
                        state_q  <= ST_IDLE;
                    end else if (wd_fire_s) begin
                        // Truncated packet: no padding, downstream never sees tlast.
                        grant_q         <= {NUM_REQ{1'b0}};
                        rr_ptr_q        <= rr_index(owner_q, 1);
                        wd_cnt_q        <= {WDW{1'b0}};
                        timeout_pulse_q <= 1'b1;
                        state_q         <= ST_IDLE;
                    end else if (hs_s || m_tvalid || !WD_EN) begin
                        // A valid owner stalled by the UART is not idle.
                        wd_cnt_q <= {WDW{1'b0}};
                        state_q  <= ST_BUSY;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + {{(WDW-1){1'b0}}, 1'b1};
                        state_q  <= ST_BUSY;
                    end
                end
                default: begin
                    state_q         <= ST_IDLE;
                    grant_q         <= {NUM_REQ{1'b0}};
                    owner_q         <= {PW{1'b0}};
                    rr_ptr_q        <= {PW{1'b0}};
                    wd_cnt_q        <= {WDW{1'b0}};
                    timeout_pulse_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Scoreboard bench for uart_tx_arbiter. Requester sources play queued
// packets (with per-beat idle gaps); a packet-rule reference model consumes
// the same inputs and pushes expected grant/release/timeout events (with the
// cycle they must appear in) and each presented beat is queued per source.
// An independent monitor pops and compares whenever the DUT shows a grant
// change, a handshake or a timeout pulse.
// ----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int WL   = 8;
    localparam int TO   = 16;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [NREQ*WL-1:0]   s_tdata;
    logic [NREQ-1:0]      s_tvalid;
    logic [NREQ-1:0]      s_tlast;
    logic [NREQ-1:0]      s_tready;
    logic [WL-1:0]        m_tdata;
    logic                 m_tvalid;
    logic                 m_tlast;
    logic                 m_tready;
    logic [NREQ-1:0]      grant;
    logic                 timeout_pulse;

    uart_tx_arbiter #(
        .NUM_REQ    (NREQ),
        .WORD_LENGTH(WL),
        .TIMEOUT    (TO)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .s_tdata      (s_tdata),
        .s_tvalid     (s_tvalid),
        .s_tlast      (s_tlast),
        .s_tready     (s_tready),
        .m_tdata      (m_tdata),
        .m_tvalid     (m_tvalid),
        .m_tlast      (m_tlast),
        .m_tready     (m_tready),
        .grant        (grant),
        .timeout_pulse(timeout_pulse)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  gap;
        logic        last;
        logic [7:0]  data;
    } beat_t;

    typedef struct packed {
        logic [31:0] who;
        logic [31:0] cyc;
    } ev_t;

    beat_t      src_q [NREQ][$];
    logic [8:0] exp_q [NREQ][$];
    ev_t        exp_grant_q[$];
    ev_t        exp_rel_q[$];
    ev_t        exp_to_q[$];

    int  cyc = 0;
    int  n_chk = 0;
    int  n_fail = 0;
    int  wait_expired = 0;
    bit  done = 1'b0;
    bit  rand_ready = 1'b0;

    int  mdl_owner = -1;
    int  mdl_ptr = 0;
    int  mdl_idle = 0;
    bit  pres [NREQ];
    int  waited [NREQ];

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- stimulus side ----------------
    task automatic add_pkt(input int r, input int n, input logic [7:0] d0,
                           input int gap_max, input bit with_last);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.gap  = 8'($urandom_range(0, gap_max));
            b.last = with_last && (i == n - 1);
            b.data = d0 + 8'(i);
            src_q[r].push_back(b);
        end
    endtask

    task automatic release_owner(input bit by_timeout);
        ev_t ev;
        ev.who = 32'(mdl_owner);
        ev.cyc = 32'(cyc + 1);
        exp_rel_q.push_back(ev);
        if (by_timeout) exp_to_q.push_back(ev);
        mdl_ptr   = (mdl_owner + 1) % NREQ;
        mdl_owner = -1;
        mdl_idle  = 0;
    endtask

    // Packet rules: idle picks the first valid from the pointer; an owner
    // keeps the bus until a tlast beat is accepted or TO idle cycles pass.
    task automatic model_step();
        bit  found;
        int  r;
        int  g;
        ev_t ev;
        if (mdl_owner < 0) begin
            found = 1'b0;
            for (int k = 0; k < NREQ; k++) begin
                r = (mdl_ptr + k) % NREQ;
                if (!found && s_tvalid[r]) begin
                    found     = 1'b1;
                    mdl_owner = r;
                    mdl_idle  = 0;
                    ev.who    = 32'(r);
                    ev.cyc    = 32'(cyc + 1);
                    exp_grant_q.push_back(ev);
                end
            end
        end else begin
            g = mdl_owner;
            if (s_tvalid[g] && m_tready) begin
                mdl_idle = 0;
                if (s_tlast[g]) release_owner(1'b0);
            end else if (!s_tvalid[g]) begin
                mdl_idle++;
                if (mdl_idle == TO) release_owner(1'b1);
            end else begin
                mdl_idle = 0;
            end
        end
    endtask

    task automatic drive_update(input logic [NREQ-1:0] hs);
        for (int r = 0; r < NREQ; r++) begin
            if (hs[r]) begin
                void'(src_q[r].pop_front());
                pres[r]   = 1'b0;
                waited[r] = 0;
            end
            if (!pres[r] && src_q[r].size() > 0) begin
                if (waited[r] >= int'(src_q[r][0].gap)) begin
                    pres[r] = 1'b1;
                    exp_q[r].push_back({src_q[r][0].last, src_q[r][0].data});
                end else begin
                    waited[r]++;
                end
            end
            if (pres[r]) begin
                s_tvalid[r]          = 1'b1;
                s_tlast[r]           = src_q[r][0].last;
                s_tdata[r*WL +: WL]  = src_q[r][0].data;
            end else begin
                s_tvalid[r]          = 1'b0;
                s_tlast[r]           = 1'($urandom_range(0, 1));
                s_tdata[r*WL +: WL]  = 8'($urandom);
            end
        end
    endtask

    task automatic tick();
        logic [NREQ-1:0] hs;
        @(negedge clk);
        model_step();
        hs = s_tvalid & s_tready;
        @(posedge clk);
        #1;
        drive_update(hs);
        if (rand_ready) m_tready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic flush_all();
        for (int r = 0; r < NREQ; r++) begin
            src_q[r].delete();
            exp_q[r].delete();
            pres[r]   = 1'b0;
            waited[r] = 0;
        end
        exp_grant_q.delete();
        exp_rel_q.delete();
        exp_to_q.delete();
        mdl_owner = -1;
        mdl_ptr   = 0;
        mdl_idle  = 0;
        s_tvalid  = '0;
    endtask

    // Reset asserted mid-cycle (2 time units after the edge).
    task automatic do_reset();
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        flush_all();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    function automatic bit all_quiet();
        bit q;
        q = (mdl_owner < 0);
        for (int r = 0; r < NREQ; r++) q = q && (src_q[r].size() == 0);
        return q;
    endfunction

    initial begin : stimulus
        bit got;
        reset_n  = 1'b0;
        m_tready = 1'b1;
        s_tvalid = '0;
        s_tlast  = '0;
        s_tdata  = '0;
        flush_all();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Single requester 1: A1, A2, A3 with tlast on A3.
        add_pkt(1, 3, 8'hA1, 0, 1'b1);
        run(8);
        // Pointer now at 2: 0, 2, 3 all valid -> 2, 3, 0.
        add_pkt(0, 1, 8'h10, 0, 1'b1);
        add_pkt(2, 1, 8'h12, 0, 1'b1);
        add_pkt(3, 1, 8'h13, 0, 1'b1);
        run(12);

        // Requesters 0 and 2 together from reset, 2-byte packets.
        do_reset();
        add_pkt(0, 2, 8'h20, 0, 1'b1);
        add_pkt(2, 2, 8'h30, 0, 1'b1);
        run(10);

        // All four continuously valid with single-beat packets.
        do_reset();
        for (int r = 0; r < NREQ; r++) begin
            for (int p = 0; p < 3; p++) add_pkt(r, 1, 8'(8'h80 + 8'(r*16 + p)), 0, 1'b1);
        end
        run(30);

        // Requester 3 stalls mid-packet; requester 0 pending behind it.
        add_pkt(3, 1, 8'h3C, 0, 1'b0);
        run(3);
        add_pkt(0, 2, 8'h40, 0, 1'b1);
        run(30);

        // UART backpressure for 2000 cycles with a valid owner.
        m_tready = 1'b0;
        add_pkt(1, 2, 8'h50, 0, 1'b1);
        run(2000);
        m_tready = 1'b1;
        run(10);

        // Reset mid-packet, then arbitration restarts from pointer 0.
        add_pkt(2, 6, 8'h60, 0, 1'b1);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            got = (grant == 4'b0100);
        end
        if (!got) wait_expired++;
        tick();
        do_reset();
        add_pkt(3, 1, 8'h70, 0, 1'b1);
        add_pkt(1, 1, 8'h71, 0, 1'b1);
        run(10);

        // Random traffic; occasional long gaps provoke watchdog releases.
        rand_ready = 1'b1;
        for (int i = 0; i < 600; i++) begin
            for (int r = 0; r < NREQ; r++) begin
                if (src_q[r].size() < 6 && $urandom_range(0, 15) == 0) begin
                    add_pkt(r, $urandom_range(1, 4), 8'($urandom),
                            ($urandom_range(0, 7) == 0) ? 24 : 2, 1'b1);
                end
            end
            tick();
        end

        rand_ready = 1'b0;
        m_tready   = 1'b1;
        got = all_quiet();
        for (int i = 0; i < 400 && !got; i++) begin
            tick();
            got = all_quiet();
        end
        if (!got) wait_expired++;
        run(4);
        done = 1'b1;
    end

    // ---------------- checking side ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        int idx;
        idx = 0;
        for (int i = NREQ - 1; i >= 0; i--) if (v[i]) idx = i;
        return idx;
    endfunction

    initial begin : monitor
        logic [NREQ-1:0] prev_grant;
        logic [NREQ-1:0] exp_vec;
        logic [8:0]      exp_beat;
        ev_t             ev;
        int              o;
        prev_grant = '0;
        forever begin
            @(negedge clk);
            if (done) begin
                chk("left_grants", 64'(exp_grant_q.size()), 64'd0);
                chk("left_releases", 64'(exp_rel_q.size()), 64'd0);
                chk("left_timeouts", 64'(exp_to_q.size()), 64'd0);
                for (int r = 0; r < NREQ; r++) chk("left_beats", 64'(exp_q[r].size()), 64'd0);
                chk("wait_bounds", 64'(wait_expired), 64'd0);
                $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
                $finish;
            end else if (!reset_n) begin
                chk("reset_outputs", 64'({grant, s_tready, m_tvalid, m_tlast, timeout_pulse, m_tdata}), 64'd0);
                prev_grant = '0;
            end else begin
                if (grant != prev_grant) begin
                    if (prev_grant != '0) begin
                        chk("bubble", 64'(grant), 64'd0);
                        if (exp_rel_q.size() == 0) begin
                            chk("release_extra", 64'(exp_rel_q.size()), 64'd1);
                        end else begin
                            ev = exp_rel_q.pop_front();
                            exp_vec = {{(NREQ-1){1'b0}}, 1'b1} << ev.who;
                            chk("release_owner", 64'(prev_grant), 64'(exp_vec));
                            chk("release_cycle", 64'(cyc), 64'(ev.cyc));
                        end
                    end
                    if (grant != '0) begin
                        if (exp_grant_q.size() == 0) begin
                            chk("grant_extra", 64'(grant), 64'd0);
                        end else begin
                            ev = exp_grant_q.pop_front();
                            exp_vec = {{(NREQ-1){1'b0}}, 1'b1} << ev.who;
                            chk("grant_owner", 64'(grant), 64'(exp_vec));
                            chk("grant_cycle", 64'(cyc), 64'(ev.cyc));
                        end
                    end
                end
                if (grant == '0) begin
                    chk("idle_outputs", 64'({m_tvalid, m_tlast, s_tready, m_tdata}), 64'd0);
                end else begin
                    chk("s_tready", 64'(s_tready), 64'(grant & {NREQ{m_tready}}));
                end
                if (m_tvalid && m_tready) begin
                    o = onehot_idx(grant);
                    if (exp_q[o].size() == 0) begin
                        chk("beat_extra", 64'(exp_q[o].size()), 64'd1);
                    end else begin
                        exp_beat = exp_q[o].pop_front();
                        chk("beat", 64'({m_tlast, m_tdata}), 64'(exp_beat));
                    end
                end
                if (timeout_pulse) begin
                    if (exp_to_q.size() == 0) begin
                        chk("timeout_extra", 64'(exp_to_q.size()), 64'd1);
                    end else begin
                        ev = exp_to_q.pop_front();
                        chk("timeout_cycle", 64'(cyc), 64'(ev.cyc));
                    end
                end
                prev_grant = grant;
            end
        end
    end

    initial begin : global_limit
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "global time limit reached");
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Packet-level round-robin arbiter that shares the single UART transmit stream (TX FIFO slave port: tx_data/tx_data_valid/tx_data_last/tx_data_ready) between NUM_REQ independent AXI-stream requesters. A grant is held for a whole packet, terminated by tlast, so bytes from different requesters never interleave on the serial line. A per-grant idle watchdog releases a requester that stalls mid-packet. The block sits directly in front of the uart top level.

Parameters:
NUM_REQ, 4, number of requester ports (2..8)
WORD_LENGTH, 8, data width per beat; matches uart WORD_LENGTH
TIMEOUT, 1024, consecutive cycles with s_tvalid low mid-packet before forced release; 0 disables the watchdog
CW, $clog2(TIMEOUT+1), watchdog counter width (derived, not overridden)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
s_tdata  input  NUM_REQ*WORD_LENGTH  requester data, requester i at bits [i*WORD_LENGTH +: WORD_LENGTH]
s_tvalid  input  NUM_REQ  requester valid
s_tlast  input  NUM_REQ  requester end-of-packet
s_tready  output  NUM_REQ  requester ready
m_tdata  output  WORD_LENGTH  to uart tx_data
m_tvalid  output  1  to uart tx_data_valid
m_tlast  output  1  to uart tx_data_last
m_tready  input  1  from uart tx_data_ready
grant  output  NUM_REQ  one-hot current owner, all-zero when idle
timeout_pulse  output  1  one-cycle pulse on watchdog release

Behaviour:
- Reset (async assert, sync-style deassert usage): state=IDLE, grant=0, rr_ptr=0, wd_cnt=0, timeout_pulse=0; hence s_tready=0, m_tvalid=0, m_tlast=0, m_tdata=0.
- States: IDLE, BUSY.
- IDLE: search s_tvalid starting at index rr_ptr, wrapping modulo NUM_REQ; first set bit wins. On a hit, register grant=onehot(winner) and go to BUSY. No data moves in IDLE. Latency: valid seen at edge t -> grant at t+1 -> first beat may complete in the t+1 cycle.
- BUSY, owner g: m_tdata=s_tdata[g], m_tvalid=s_tvalid[g], m_tlast=s_tlast[g], s_tready[g]=m_tready. All other s_tready=0. Outputs are combinational from the registered grant and the owner inputs only; no cross-requester path.
- Handshake = m_tvalid & m_tready. A handshake with m_tlast=1 ends the packet: grant->0, rr_ptr=(g+1) mod NUM_REQ, state->IDLE, wd_cnt->0. The next arbitration occurs in the following IDLE cycle, so there is exactly one bubble cycle between packets.
- Watchdog (TIMEOUT>0): in BUSY, wd_cnt clears on a handshake or when s_tvalid[g]=1, otherwise increments. When wd_cnt==TIMEOUT-1 and s_tvalid[g]=0: release exactly as for tlast (rr_ptr=g+1), and assert timeout_pulse for 1 cycle. The truncated packet is not padded; the downstream sees no tlast.
- Backpressure: if m_tready=0 and s_tvalid[g]=1, the watchdog does not count; a stall by the UART never triggers release.
- A requester that raises and drops s_tvalid in IDLE without a handshake may still be granted; the granted port then waits, subject to the watchdog.
- Single-beat packets (tlast on the first beat) are legal: grant lasts 1 cycle if m_tready=1.
- Requester inputs other than the owner are ignored in BUSY; starvation is bounded because rr_ptr always moves past the last owner.
- An asynchronous reset_n assertion mid-packet drops the grant immediately and m_tvalid falls combinationally. A partially sent packet stays partial.
- m_tdata is 0 when grant=0 (mux is AND-OR with the grant).

Test Plan:
- Single requester 1 sends 3 bytes 0xA1,0xA2,0xA3 (last on 0xA3), m_tready=1 -> grant=4'b0010 the cycle after valid; m_tdata shows A1,A2,A3 on consecutive cycles with m_tlast on A3; then grant=0 and rr_ptr=2.
- Requesters 0 and 2 valid together from reset, each with 2-byte packets -> req0's packet completes fully first, one idle cycle, then req2's packet. No interleaving.
- All 4 requesters continuously valid with 1-byte packets -> grant sequence 0,1,2,3,0,1; each grant lasts 1 cycle, separated by 1 IDLE cycle.
- Requester 3 sends 1 byte without tlast then drops valid, with TIMEOUT=16 -> 16 cycles after the last handshake: timeout_pulse=1 for 1 cycle, grant=0, and a pending requester 0 is granted next.
- m_tready held 0 for 2000 cycles while the owner is valid, with TIMEOUT=1024 -> no timeout_pulse, grant held, data stable; on m_tready=1 the beat transfers.
- reset_n pulled low mid-packet -> within the same cycle m_tvalid=0, s_tready=0, grant=0. After release, arbitration restarts from rr_ptr=0.
